// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the assoc_cache data cache.
//   state_e      - controller FSM states
//   idx_w/age_w  - derived widths (index bits, per-line LRU age bits)
//   merge_bytes  - byte-enable merge of CPU write data into a line word
package cache_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      StIdle,
      StWriteback,
      StRefill,
      StComplete
   } state_e;

   function automatic int unsigned idx_w(input int unsigned sets);
      return $clog2(sets);
   endfunction

   // A direct-mapped cache still carries a 1-bit (constant) age field.
   function automatic int unsigned age_w(input int unsigned ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old_data,
                                                     input logic [WORD_W-1:0] new_data,
                                                     input logic [3:0]        be);
      logic [WORD_W-1:0] res;
      res = old_data;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_data[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/assoc_cache_if.sv
// assoc_cache_if: CPU-side request bus plus memory-side handshake of the data cache.
//   CPU side : ren, wen, byte_selector, address, datawr -> cache; dataout, stall <- cache
//   Memory   : mem_req, mem_we, mem_addr, mem_wdata <- cache; mem_rdata, mem_ack -> cache
//   slave modport is the cache, master modport is the CPU/memory environment.
interface assoc_cache_if;

   logic        ren;
   logic        wen;
   logic [3:0]  byte_selector;
   logic [31:0] address;
   logic [31:0] datawr;
   logic [31:0] dataout;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  ren, wen, byte_selector, address, datawr, mem_rdata, mem_ack,
      output dataout, stall, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output ren, wen, byte_selector, address, datawr, mem_rdata, mem_ack,
      input  dataout, stall, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/cache_lru_set.sv
// cache_lru_set: true-LRU age logic for one cache set (purely combinational).
//   access_valid_i - an access to this set completes this cycle
//   access_way_i   - way being accessed
//   valid_i        - per-way valid bits
//   age_i          - current per-way ages (0 = MRU)
//   victim_way_o   - first invalid way, else the way with the oldest age
//   age_o          - ages after this cycle's access (unchanged when no access)
module cache_lru_set #(
   parameter int unsigned WAYS  = 2,
   parameter int unsigned AGE_W = 1
) (
   input  logic                       access_valid_i,
   input  logic [AGE_W-1:0]           access_way_i,
   input  logic [WAYS-1:0]            valid_i,
   input  logic [WAYS-1:0][AGE_W-1:0] age_i,
   output logic [AGE_W-1:0]           victim_way_o,
   output logic [WAYS-1:0][AGE_W-1:0] age_o
);

   logic             found;
   logic [AGE_W-1:0] acc_age;

   always_comb begin
      victim_way_o = '0;
      found        = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!valid_i[w] && !found) begin
            victim_way_o = AGE_W'(w);
            found        = 1'b1;
         end
      end
      if (!found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_i[w] == AGE_W'(WAYS - 1)) victim_way_o = AGE_W'(w);
         end
      end
   end

   always_comb begin
      acc_age = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (AGE_W'(w) == access_way_i) acc_age = age_i[w];
      end
      age_o = age_i;
      if (access_valid_i) begin
         for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == access_way_i) begin
               age_o[w] = '0;
            end else if (age_i[w] < acc_age) begin
               age_o[w] = age_i[w] + AGE_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-back, write-allocate data cache.
//   clk, reset      - clock, asynchronous active-high reset
//   bus (slave)     - CPU request/response and memory request/acknowledge handshake
//   hit_count       - completed first-lookup hits (wraps)
//   miss_count      - misses (wraps)
// Lines live in flops so lookup is combinational; a miss walks
// IDLE -> [WRITEBACK] -> REFILL -> COMPLETE -> IDLE while stall is high.
module assoc_cache
   import cache_pkg::*;
#(
   parameter int unsigned SETS  = 8,
   parameter int unsigned WAYS  = 2,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   assoc_cache_if.slave     bus,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int unsigned IDX   = idx_w(SETS);
   localparam int unsigned TAG_W = WORD_W - IDX;
   localparam int unsigned AGE_W = age_w(WAYS);

   typedef struct packed {
      logic              valid;
      logic              dirty;
      logic [TAG_W-1:0]  tag;
      logic [WORD_W-1:0] data;
   } line_t;

   typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

   state_e            state_q, state_d;
   line_t             line_q [SETS][WAYS];
   line_t             line_d [SETS][WAYS];
   ages_t             age_q [SETS];
   ages_t             age_next [SETS];
   logic [AGE_W-1:0]  victim_set [SETS];
   logic [WAYS-1:0]   set_valid [SETS];
   logic [AGE_W-1:0]  victim_q, victim_d;
   logic [WORD_W-1:0] dataout_q, dataout_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [CNT_W-1:0]  hit_q, hit_d;
   logic [CNT_W-1:0]  miss_q, miss_d;
   // Set while IDLE finishes a request that already missed, so it is not counted as a hit.
   logic              retry_q, retry_d;

   logic [IDX-1:0]    idx;
   logic [TAG_W-1:0]  tag;
   logic              req;
   logic              hit;
   logic [AGE_W-1:0]  hit_way;
   line_t             hit_line;
   line_t             victim_line;
   logic              access_en;
   logic              stall;

   assign idx = bus.address[IDX-1:0];
   assign tag = bus.address[WORD_W-1:IDX];
   assign req = bus.ren ^ bus.wen;

   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      hit_line = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (line_q[idx][w].valid && (line_q[idx][w].tag == tag)) begin
            hit      = 1'b1;
            hit_way  = AGE_W'(w);
            hit_line = line_q[idx][w];
         end
      end
   end

   always_comb begin
      victim_line = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (AGE_W'(w) == victim_set[idx]) victim_line = line_q[idx][w];
      end
   end

   // COMPLETE always hits: the refill just installed the line.
   always_comb begin
      access_en = 1'b0;
      if (state_q == StIdle)     access_en = req & hit;
      if (state_q == StComplete) access_en = hit;
   end

   for (genvar s = 0; s < SETS; s++) begin : g_set
      for (genvar w = 0; w < WAYS; w++) begin : g_way
         assign set_valid[s][w] = line_q[s][w].valid;
      end
      cache_lru_set #(
         .WAYS  (WAYS),
         .AGE_W (AGE_W)
      ) u_lru (
         .access_valid_i (access_en && (idx == IDX'(s))),
         .access_way_i   (hit_way),
         .valid_i        (set_valid[s]),
         .age_i          (age_q[s]),
         .victim_way_o   (victim_set[s]),
         .age_o          (age_next[s])
      );
   end

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      victim_d    = victim_q;
      dataout_d   = dataout_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      retry_d     = 1'b0;
      stall       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (hit) begin
                  if (!retry_q) hit_d = hit_q + CNT_W'(1);
               end else begin
                  stall     = 1'b1;
                  miss_d    = miss_q + CNT_W'(1);
                  victim_d  = victim_set[idx];
                  mem_req_d = 1'b1;
                  if (victim_line.valid && victim_line.dirty) begin
                     mem_we_d    = 1'b1;
                     mem_addr_d  = {victim_line.tag, idx};
                     mem_wdata_d = victim_line.data;
                     state_d     = StWriteback;
                  end else begin
                     mem_we_d   = 1'b0;
                     mem_addr_d = bus.address;
                     state_d    = StRefill;
                  end
               end
            end
         end
         StWriteback: begin
            stall = 1'b1;
            if (bus.mem_ack) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (AGE_W'(w) == victim_q) line_d[idx][w].valid = 1'b0;
               end
               mem_we_d   = 1'b0;
               mem_addr_d = bus.address;
               state_d    = StRefill;
            end
         end
         StRefill: begin
            stall = 1'b1;
            if (bus.mem_ack) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (AGE_W'(w) == victim_q) begin
                     line_d[idx][w].valid = 1'b1;
                     line_d[idx][w].dirty = 1'b0;
                     line_d[idx][w].tag   = tag;
                     line_d[idx][w].data  = bus.mem_rdata;
                  end
               end
               mem_req_d = 1'b0;
               state_d   = StComplete;
            end
         end
         StComplete: begin
            stall   = 1'b1;
            retry_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (access_en) begin
         if (bus.ren) begin
            dataout_d = hit_line.data;
         end else begin
            for (int w = 0; w < WAYS; w++) begin
               if (AGE_W'(w) == hit_way) begin
                  line_d[idx][w].data  = merge_bytes(hit_line.data, bus.datawr,
                                                     bus.byte_selector);
                  line_d[idx][w].dirty = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         victim_q    <= '0;
         dataout_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
         retry_q     <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               line_q[s][w] <= '0;
               age_q[s][w]  <= AGE_W'(w);
            end
         end
      end else begin
         state_q     <= state_d;
         victim_q    <= victim_d;
         dataout_q   <= dataout_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         retry_q     <= retry_d;
         line_q      <= line_d;
         age_q       <= age_next;
      end
   end

   assign bus.dataout   = dataout_q;
   assign bus.stall     = stall;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign hit_count     = hit_q;
   assign miss_count    = miss_q;

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed, table-driven bench for assoc_cache.
// Two instances (2-way and 4-way, 8 sets) share one memory model; sel picks the active one.
module tb_assoc_cache;

   localparam int LAT   = 3;
   localparam int KRD   = 0;
   localparam int KWR   = 1;
   localparam int KBOTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic        ren, wen;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   logic        ack, ack_en;
   logic [31:0] rdata;
   int          cnt;
   int          tx_cnt;
   int          errors, checks;

   always #5 clk = ~clk;

   assoc_cache_if if2 ();
   assoc_cache_if if4 ();
   logic [31:0] hit2, miss2, hit4, miss4;

   assign if2.ren           = ren & ~sel;
   assign if2.wen           = wen & ~sel;
   assign if2.byte_selector = be;
   assign if2.address       = addr;
   assign if2.datawr        = wdata;
   assign if2.mem_rdata     = rdata;
   assign if2.mem_ack       = ack & ~sel;
   assign if4.ren           = ren & sel;
   assign if4.wen           = wen & sel;
   assign if4.byte_selector = be;
   assign if4.address       = addr;
   assign if4.datawr        = wdata;
   assign if4.mem_rdata     = rdata;
   assign if4.mem_ack       = ack & sel;

   assoc_cache #(.SETS(8), .WAYS(2), .CNT_W(32)) dut2 (
      .clk        (clk),
      .reset      (reset),
      .bus        (if2),
      .hit_count  (hit2),
      .miss_count (miss2)
   );

   assoc_cache #(.SETS(8), .WAYS(4), .CNT_W(32)) dut4 (
      .clk        (clk),
      .reset      (reset),
      .bus        (if4),
      .hit_count  (hit4),
      .miss_count (miss4)
   );

   logic        stall_m, mreq, mwe;
   logic [31:0] maddr, mwdata, dout_m, hit_m, miss_m;
   assign stall_m = sel ? if4.stall     : if2.stall;
   assign mreq    = sel ? if4.mem_req   : if2.mem_req;
   assign mwe     = sel ? if4.mem_we    : if2.mem_we;
   assign maddr   = sel ? if4.mem_addr  : if2.mem_addr;
   assign mwdata  = sel ? if4.mem_wdata : if2.mem_wdata;
   assign dout_m  = sel ? if4.dataout   : if2.dataout;
   assign hit_m   = sel ? hit4          : hit2;
   assign miss_m  = sel ? miss4         : miss2;

   // Memory: acks in the LAT-th cycle of a held request.
   logic [31:0] mem [logic [31:0]];
   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
   } tx_t;
   tx_t log_q[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= 0;
         ack <= 1'b0;
      end else if (!mreq || ack) begin
         cnt <= 0;
         ack <= 1'b0;
      end else begin
         cnt <= cnt + 1;
         if (cnt == LAT - 2 && ack_en) begin
            ack <= 1'b1;
            if (mwe) mem[maddr] = mwdata;
            rdata <= mem.exists(maddr) ? mem[maddr] : 32'h0;
            log_q.push_back('{we: mwe, a: maddr, d: mwdata});
            tx_cnt = tx_cnt + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_req(input logic s, input int kind, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b, output int scyc);
      @(negedge clk);
      sel   = s;
      addr  = a;
      wdata = d;
      be    = b;
      ren   = (kind != KWR);
      wen   = (kind != KRD);
      scyc  = 0;
      #1;
      while (stall_m === 1'b1 && scyc < 60) begin
         scyc++;
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      ren = 1'b0;
      wen = 1'b0;
   endtask

   typedef struct {
      logic        s;
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      int          cyc;
      logic        chk_d;
      logic [31:0] exp_d;
      int          exp_h;
      int          exp_m;
      int          exp_tx;
   } vec_t;

   vec_t vecs [21];

   initial begin
      int scyc;
      int tx0;
      errors = 0;
      checks = 0;
      tx_cnt = 0;
      reset  = 1'b1;
      sel    = 1'b0;
      ren    = 1'b0;
      wen    = 1'b0;
      be     = 4'h0;
      addr   = 32'h0;
      wdata  = 32'h0;
      ack_en = 1'b1;
      mem[32'h00] = 32'hA0A0A0A0;
      mem[32'h08] = 32'hA8A8A8A8;
      mem[32'h10] = 32'hDEADBEEF;
      mem[32'h18] = 32'h18181818;
      mem[32'h20] = 32'h20202020;

      //            sel kind   addr    wdata         be    cyc rd  data          h  m  tx
      vecs[0]  = '{1'b0, KRD,   32'h10, 32'h0,        4'h0, 5, 1'b1, 32'hDEADBEEF, 0, 1, 1};
      vecs[1]  = '{1'b0, KRD,   32'h10, 32'h0,        4'h0, 0, 1'b1, 32'hDEADBEEF, 1, 1, 0};
      vecs[2]  = '{1'b0, KWR,   32'h10, 32'h11223344, 4'h5, 0, 1'b0, 32'h0,        2, 1, 0};
      vecs[3]  = '{1'b0, KRD,   32'h10, 32'h0,        4'h0, 0, 1'b1, 32'hDE22BE44, 3, 1, 0};
      vecs[4]  = '{1'b0, KRD,   32'h18, 32'h0,        4'h0, 5, 1'b1, 32'h18181818, 3, 2, 1};
      vecs[5]  = '{1'b0, KRD,   32'h20, 32'h0,        4'h0, 8, 1'b1, 32'h20202020, 3, 3, 2};
      vecs[6]  = '{1'b0, KRD,   32'h18, 32'h0,        4'h0, 0, 1'b1, 32'h18181818, 4, 3, 0};
      vecs[7]  = '{1'b0, KRD,   32'h10, 32'h0,        4'h0, 5, 1'b1, 32'hDE22BE44, 4, 4, 1};
      vecs[8]  = '{1'b0, KBOTH, 32'h18, 32'hFFFFFFFF, 4'hF, 0, 1'b1, 32'hDE22BE44, 4, 4, 0};
      vecs[9]  = '{1'b0, KRD,   32'h20, 32'h0,        4'h0, 5, 1'b1, 32'h20202020, 4, 5, 1};
      vecs[10] = '{1'b0, KRD,   32'h10, 32'h0,        4'h0, 0, 1'b1, 32'hDE22BE44, 5, 5, 0};
      vecs[11] = '{1'b0, KRD,   32'h18, 32'h0,        4'h0, 5, 1'b1, 32'h18181818, 5, 6, 1};
      vecs[12] = '{1'b1, KRD,   32'h00, 32'h0,        4'h0, 5, 1'b1, 32'hA0A0A0A0, 0, 1, 1};
      vecs[13] = '{1'b1, KRD,   32'h08, 32'h0,        4'h0, 5, 1'b1, 32'hA8A8A8A8, 0, 2, 1};
      vecs[14] = '{1'b1, KRD,   32'h10, 32'h0,        4'h0, 5, 1'b1, 32'hDE22BE44, 0, 3, 1};
      vecs[15] = '{1'b1, KRD,   32'h18, 32'h0,        4'h0, 5, 1'b1, 32'h18181818, 0, 4, 1};
      vecs[16] = '{1'b1, KRD,   32'h00, 32'h0,        4'h0, 0, 1'b1, 32'hA0A0A0A0, 1, 4, 0};
      vecs[17] = '{1'b1, KRD,   32'h20, 32'h0,        4'h0, 5, 1'b1, 32'h20202020, 1, 5, 1};
      vecs[18] = '{1'b1, KRD,   32'h00, 32'h0,        4'h0, 0, 1'b1, 32'hA0A0A0A0, 2, 5, 0};
      vecs[19] = '{1'b1, KRD,   32'h08, 32'h0,        4'h0, 5, 1'b1, 32'hA8A8A8A8, 2, 6, 1};
      vecs[20] = '{1'b1, KRD,   32'h10, 32'h0,        4'h0, 5, 1'b1, 32'hDE22BE44, 2, 7, 1};

      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk($sformatf("rst%0d_dataout", s), dout_m, 32'h0);
         chk($sformatf("rst%0d_stall", s), {31'h0, stall_m}, 32'h0);
         chk($sformatf("rst%0d_mem_req", s), {31'h0, mreq}, 32'h0);
         chk($sformatf("rst%0d_hits", s), hit_m, 32'h0);
         chk($sformatf("rst%0d_misses", s), miss_m, 32'h0);
      end
      sel = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         tx0 = tx_cnt;
         run_req(vecs[i].s, vecs[i].kind, vecs[i].a, vecs[i].d, vecs[i].b, scyc);
         chk($sformatf("v%0d_stall_cycles", i), 32'(scyc), 32'(vecs[i].cyc));
         if (vecs[i].chk_d) chk($sformatf("v%0d_dataout", i), dout_m, vecs[i].exp_d);
         chk($sformatf("v%0d_hits", i), hit_m, 32'(vecs[i].exp_h));
         chk($sformatf("v%0d_misses", i), miss_m, 32'(vecs[i].exp_m));
         chk($sformatf("v%0d_mem_tx", i), 32'(tx_cnt - tx0), 32'(vecs[i].exp_tx));
      end

      // Memory traffic of the cold miss and the dirty eviction in the 2-way run.
      if (log_q.size() >= 4) begin
         chk("tx0_we", {31'h0, log_q[0].we}, 32'h0);
         chk("tx0_addr", log_q[0].a, 32'h10);
         chk("tx2_we", {31'h0, log_q[2].we}, 32'h1);
         chk("tx2_addr", log_q[2].a, 32'h10);
         chk("tx2_wdata", log_q[2].d, 32'hDE22BE44);
         chk("tx3_we", {31'h0, log_q[3].we}, 32'h0);
         chk("tx3_addr", log_q[3].a, 32'h20);
      end else begin
         chk("tx_log_size", 32'(log_q.size()), 32'h4);
      end

      // Reset while a refill is outstanding and never acknowledged.
      ack_en = 1'b0;
      @(negedge clk);
      sel  = 1'b0;
      addr = 32'h20;
      ren  = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rmid_req_before", {31'h0, mreq}, 32'h1);
      ren   = 1'b0;
      reset = 1'b1;
      #1;
      chk("rmid_req_drop", {31'h0, mreq}, 32'h0);
      chk("rmid_dataout", dout_m, 32'h0);
      chk("rmid_mem_addr", maddr, 32'h0);
      chk("rmid_hits", hit_m, 32'h0);
      chk("rmid_misses", miss_m, 32'h0);
      @(negedge clk);
      reset  = 1'b0;
      ack_en = 1'b1;
      tx0    = tx_cnt;
      run_req(1'b0, KRD, 32'h10, 32'h0, 4'h0, scyc);
      chk("rpost_stall_cycles", 32'(scyc), 32'd5);
      chk("rpost_dataout", dout_m, 32'hDE22BE44);
      chk("rpost_misses", miss_m, 32'h1);
      chk("rpost_hits", hit_m, 32'h0);
      chk("rpost_mem_tx", 32'(tx_cnt - tx0), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache between the pipeline MEM stage and the word-addressed data memory.
- Adds over the previous 2-way cache:
  - configurable sets and ways;
  - true-LRU replacement;
  - explicit stall output;
  - request/acknowledge memory handshake carrying the victim address;
  - hit and miss performance counters.

Parameters:
- SETS, 8, number of sets; power of two, at least 2.
- WAYS, 2, associativity; power of two, 1 to 8.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ren  in  1  CPU read request.
- wen  in  1  CPU write request.
- byte_selector  in  4  byte enables for writes; bit3 enables data[31:24].
- address  in  32  word address; index = address[IDX-1:0], tag = address[31:IDX], IDX = log2(SETS).
- datawr  in  32  CPU write data.
- dataout  out  32  read data; registered.
- stall  out  1  request not complete; CPU holds ren, wen, address, datawr and byte_selector stable while high.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = writeback, 0 = refill.
- mem_addr  out  32  word address of the memory request.
- mem_wdata  out  32  victim data.
- mem_rdata  in  32  refill data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- hit_count  out  CNT_W  completed first-lookup hits.
- miss_count  out  CNT_W  misses.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all valid, dirty and LRU age state (way w age = w);
  - dataout, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count;
  - FSM returns to IDLE.
- Reset mid-miss: mem_req drops immediately; memory must tolerate the abandoned request.
- Request definition: exactly one of ren/wen high. ren&wen together is ignored: no state change, stall=0.
- Line format: valid, dirty, tag (32-IDX bits), 32-bit data. Line storage is flops, not RAM (combinational lookup).
- LRU: per-line age of log2(WAYS) bits, 0 = MRU.
  - On any access to way k: every way with age < age(k) increments; age(k) becomes 0.
  - Victim: an invalid way if any (lowest index first), else the way with age = WAYS-1.
- FSM states: IDLE, WRITEBACK, REFILL, COMPLETE.
- IDLE:
  - Combinational lookup on address.
  - Hit: stall=0; done this cycle.
    - Read: dataout <= line data at the next edge.
    - Write: bytes merged per byte_selector; dirty set.
    - Both: LRU updated, hit_count++.
  - Miss: stall=1 combinationally and miss_count++.
    - Victim valid and dirty: go to WRITEBACK, with mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data.
    - Otherwise: go to REFILL, with mem_req=1, mem_we=0, mem_addr=address.
- WRITEBACK: stall=1. On mem_ack: victim valid cleared; go to REFILL (request fields switch next cycle; mem_req stays 1).
- REFILL: stall=1. On mem_ack:
  - line <= {valid=1, dirty=0, tag, mem_rdata} in the victim way;
  - mem_req <= 0;
  - go to COMPLETE.
- COMPLETE: stall=1. Re-executes the held request as a hit (read: dataout registered; write: merge, dirty=1), LRU updated, hit_count not incremented; go to IDLE.
- stall falls in the cycle after COMPLETE, when the IDLE lookup hits.
  - Clean-miss latency: 2 + memory latency cycles.
  - Dirty-miss latency: adds one writeback round trip.
- A read miss on data never written still refills from memory. X data is not treated as invalid.
- mem_ack outside WRITEBACK/REFILL is ignored.
- Counters wrap modulo 2^CNT_W.
- dataout holds its last value when there is no read.
- WAYS=1 degenerates to direct-mapped: age width forced to 1, unused.

Decomposition:
- Package cache_pkg:
  - FSM state enum;
  - localparams IDX = $clog2(SETS), TAG_W, AGE_W;
  - line struct {valid, dirty, tag, data}.
- Sub-module cache_lru_set: one set's age vector.
  - Inputs: access_valid, access_way, valid bits.
  - Outputs: victim_way, next ages.
  - Instantiated SETS times.

Test Plan:
- Cold read miss, SETS=8, WAYS=2: read 0x10 with memory returning 0xDEADBEEF after 3 cycles -> exactly one refill request with mem_addr=0x10; stall high for 5 cycles; dataout=0xDEADBEEF; miss_count=1; immediate reread hits, stall=0, hit_count=1.
- Byte write hit: line at 0x10 holds 0xDEADBEEF; write datawr=0x11223344 with byte_selector=0101 -> later read returns 0xDE22BE44; no memory traffic.
- LRU plus dirty eviction: addresses 0x10, 0x18, 0x20 share set 0; write 0x10, read 0x18, then read 0x20 -> writeback of dirty 0x10 (mem_we=1, mem_addr=0x10) then refill of 0x20; 0x18 remains a hit.
- WAYS=4 replacement: sequence 0x00, 0x08, 0x10, 0x18, 0x00, 0x20 -> 0x08 evicted; 0x00 still hits.
- Simultaneous ren&wen at a cached address -> no data, LRU or counter change; stall=0.
- Reset asserted during REFILL, with mem_ack never returned -> mem_req=0 immediately; all lines invalid; subsequent read of a previously cached address misses.
